// File: rtl/id_stage.sv
// ============================================================================
// Module   : id_stage
// Purpose  : RV64I decode stage with operand forwarding, immediate generation,
//            optional load-use stall (macro ID_LOAD_USE_STALL_EN) and a
//            valid/ready output register with flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_stage #(
  parameter int XLEN = 64,
  parameter int NFWD = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          inst_i,
  input  logic [XLEN-1:0]      pc_i,
  output logic [4:0]           rs1_addr_o,
  output logic [4:0]           rs2_addr_o,
  input  logic [XLEN-1:0]      rs1_data_i,
  input  logic [XLEN-1:0]      rs2_data_i,
  input  logic [NFWD-1:0]      fwd_wreg_i,
  input  logic [5*NFWD-1:0]    fwd_rd_addr_i,
  input  logic [XLEN*NFWD-1:0] fwd_wdata_i,
  input  logic                 ex_is_load_i,
  input  logic                 flush_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [6:0]           opcode_o,
  output logic [2:0]           funct3_o,
  output logic [6:0]           funct7_o,
  output logic [4:0]           rd_addr_o,
  output logic                 wreg_o,
  output logic [XLEN-1:0]      rs1_data_o,
  output logic [XLEN-1:0]      rs2_data_o,
  output logic [XLEN-1:0]      imm_o,
  output logic [XLEN-1:0]      pc_o
);

  localparam logic [6:0] C_OP_LUI    = 7'b0110111;
  localparam logic [6:0] C_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] C_OP_JAL    = 7'b1101111;
  localparam logic [6:0] C_OP_JALR   = 7'b1100111;
  localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OP_STORE  = 7'b0100011;
  localparam logic [6:0] C_OP_IMM    = 7'b0010011;
  localparam logic [6:0] C_OP_IMM32  = 7'b0011011;
  localparam logic [6:0] C_OP_REG    = 7'b0110011;
  localparam logic [6:0] C_OP_REG32  = 7'b0111011;

  logic [6:0]      w_opcode;
  logic [4:0]      w_rd;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic            w_is_b;
  logic            w_is_s;
  logic            w_wreg;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic            w_hazard;
  logic            w_advance;
  logic            w_load;

  logic            r_valid;
  logic [6:0]      r_opcode;
  logic [2:0]      r_funct3;
  logic [6:0]      r_funct7;
  logic [4:0]      r_rd;
  logic            r_wreg;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;
  logic [XLEN-1:0] r_pc;

  assign w_opcode = inst_i[6:0];
  assign w_rd     = inst_i[11:7];
  assign w_funct3 = inst_i[14:12];
  assign w_rs1    = inst_i[19:15];
  assign w_rs2    = inst_i[24:20];
  assign w_funct7 = inst_i[31:25];

  assign rs1_addr_o = w_rs1;
  assign rs2_addr_o = w_rs2;

  assign w_is_b = (w_opcode == C_OP_BRANCH);
  assign w_is_s = (w_opcode == C_OP_STORE);
  assign w_wreg = !(w_is_b || w_is_s) && (w_rd != 5'd0);

  always_comb begin
    w_imm = '0;
    case (w_opcode)
      C_OP_IMM, C_OP_IMM32, C_OP_LOAD, C_OP_JALR:
        w_imm = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
      C_OP_STORE:
        w_imm = {{(XLEN-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      C_OP_BRANCH:
        w_imm = {{(XLEN-13){inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                 inst_i[11:8], 1'b0};
      C_OP_LUI, C_OP_AUIPC:
        w_imm = {{(XLEN-32){inst_i[31]}}, inst_i[31:12], 12'b0};
      C_OP_JAL:
        w_imm = {{(XLEN-21){inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                 inst_i[30:21], 1'b0};
      default:
        w_imm = '0;
    endcase
  end

  // Walk slots from highest to lowest index so the lowest matching slot wins.
  always_comb begin
    w_rs1_val = rs1_data_i;
    w_rs2_val = rs2_data_i;
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (fwd_wreg_i[k] && (fwd_rd_addr_i[5*k +: 5] == w_rs1))
        w_rs1_val = fwd_wdata_i[XLEN*k +: XLEN];
      if (fwd_wreg_i[k] && (fwd_rd_addr_i[5*k +: 5] == w_rs2))
        w_rs2_val = fwd_wdata_i[XLEN*k +: XLEN];
    end
    if (w_rs1 == 5'd0)
      w_rs1_val = '0;
    if (w_rs2 == 5'd0)
      w_rs2_val = '0;
  end

`ifdef ID_LOAD_USE_STALL_EN
  logic       w_use_rs1;
  logic       w_use_rs2;
  logic [4:0] w_rd0;

  assign w_use_rs1 = !((w_opcode == C_OP_LUI) || (w_opcode == C_OP_AUIPC) ||
                       (w_opcode == C_OP_JAL));
  assign w_use_rs2 = (w_opcode == C_OP_REG) || (w_opcode == C_OP_REG32) ||
                     w_is_s || w_is_b;
  assign w_rd0     = fwd_rd_addr_i[4:0];
  assign w_hazard  = ex_is_load_i && fwd_wreg_i[0] && (w_rd0 != 5'd0) &&
                     ((w_use_rs1 && (w_rs1 == w_rd0)) ||
                      (w_use_rs2 && (w_rs2 == w_rd0)));
`else
  logic w_unused_ld;

  // Without the interlock the compiler schedules around load-use pairs.
  assign w_unused_ld = ex_is_load_i;
  assign w_hazard    = 1'b0;
`endif

  assign w_advance = !r_valid || out_ready;
  assign in_ready  = w_advance && !w_hazard && !flush_i;
  assign w_load    = w_advance && in_valid && !w_hazard;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid    <= 1'b0;
      r_opcode   <= '0;
      r_funct3   <= '0;
      r_funct7   <= '0;
      r_rd       <= '0;
      r_wreg     <= 1'b0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_pc       <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid    <= 1'b1;
      r_opcode   <= w_opcode;
      r_funct3   <= w_funct3;
      r_funct7   <= w_funct7;
      r_rd       <= w_rd;
      r_wreg     <= w_wreg;
      r_rs1_data <= w_rs1_val;
      r_rs2_data <= w_rs2_val;
      r_imm      <= w_imm;
      r_pc       <= pc_i;
    end else if (w_advance) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid  = r_valid;
  assign opcode_o   = r_opcode;
  assign funct3_o   = r_funct3;
  assign funct7_o   = r_funct7;
  assign rd_addr_o  = r_rd;
  assign wreg_o     = r_wreg;
  assign rs1_data_o = r_rs1_data;
  assign rs2_data_o = r_rs2_data;
  assign imm_o      = r_imm;
  assign pc_o       = r_pc;

endmodule

`default_nettype wire

// File: doc/id_stage.md
# id_stage

Registered, parametrised instruction-decode stage that sits between the IF/ID and EX boundaries of the pipeline. It splits RV64I instructions into fields, reads and forwards source operands from NFWD write-back sources, and generates fully sign-extended XLEN-wide immediates. It detects load-use hazards and stalls the front end. Results are held in an output register behind a valid/ready handshake, with flush support.

## Interface

Parameters:
- XLEN, 64, datapath and PC width.
- NFWD, 3, number of forwarding sources. Slot 0 is EX, slot 1 is MEM, slot 2 is MEM/WB. A lower slot index has higher priority.

Ports (`clk` is the single clock; `rst` is the asynchronous, active-low reset):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream holds a valid inst_i/pc_i.
- in_ready  out  1  stage accepts the input this cycle.
- inst_i  in  32  instruction word.
- pc_i  in  XLEN  PC of inst_i.
- rs1_addr_o, rs2_addr_o  out  5  combinational regfile read addresses (inst_i[19:15], inst_i[24:20]).
- rs1_data_i, rs2_data_i  in  XLEN  regfile read data.
- fwd_wreg_i  in  NFWD  per-slot write enable.
- fwd_rd_addr_i  in  5*NFWD  per-slot destination; slot k occupies bits [5k+4:5k].
- fwd_wdata_i  in  XLEN*NFWD  per-slot write data.
- ex_is_load_i  in  1  the slot-0 (EX) instruction is a load; its data is not yet available.
- flush_i  in  1  squash the stage (branch or jump redirect).
- out_valid  out  1  output register holds a valid instruction.
- out_ready  in  1  EX accepts the output.
- opcode_o 7, funct3_o 3, funct7_o 7, rd_addr_o 5, wreg_o 1, rs1_data_o XLEN, rs2_data_o XLEN, imm_o XLEN, pc_o XLEN  out  registered decode results.

## Operation

- Decode is combinational on inst_i. All outputs except in_ready and rs*_addr_o are registered.
- use_rs1 is 0 for LUI (0110111), AUIPC (0010111) and JAL (1101111), and 1 otherwise.
- use_rs2 is 1 for R (0110011), R-W (0111011), S (0100011) and B (1100011).
- Operand select, applied per source: if the address is x0, the result is 0. Otherwise the lowest-index slot k with fwd_wreg_i[k]=1 and a matching rd supplies fwd_wdata_i slot k. If no slot matches, the regfile data is used.
- wreg: 0 for B and S types, and 0 whenever rd=x0. All other opcodes give 1.
- imm_o, always sign-extended from inst_i[31]:
  - I-type/load/JALR: inst[31:20].
  - S: {inst[31:25],inst[11:7]}.
  - B: {inst[31],inst[7],inst[30:25],inst[11:8],0}.
  - U: {inst[31:12],12'b0}.
  - J: {inst[31],inst[19:12],inst[20],inst[30:21],0}.
  - All other opcodes: 0.
- hazard = ex_is_load_i & fwd_wreg_i[0] & (rd0≠0) & ((use_rs1 & rs1==rd0) | (use_rs2 & rs2==rd0)).
- advance = !out_valid | out_ready.
- in_ready = advance & !hazard & !flush_i.
- Register update on each clock, first matching case wins:
  - flush_i=1: out_valid←0.
  - advance & in_valid & !hazard: load the decode results, out_valid←1.
  - advance (a hazard, or no input): out_valid←0, inserting a bubble.
  - Otherwise: hold all outputs unchanged.
- Stall behaviour: upstream keeps inst_i stable while in_ready=0. Forwarding is re-evaluated every cycle, so the retry picks up the load result from slot 1.

## Timing

- Reset: out_valid=0, and opcode/funct/rd/wreg/data/imm/pc outputs are all 0. Reset takes effect asynchronously on the falling edge of rst; release is synchronous to clk.
- Latency: one cycle from acceptance to out_valid.
- Throughput: one instruction per cycle with no hazards and out_ready=1.
- A load-use hazard costs exactly one bubble cycle.
- Output data is stable while out_valid=1 and out_ready=0.
- Forwarding inputs are sampled in the acceptance cycle only.
- flush_i concurrent with a hazard or backpressure: flush wins. The next cycle out_valid=0 and no input is consumed.
- rst asserted mid-stall: the state clears immediately, and in_ready is recomputed from the inputs.

## Configuration

- ID_LOAD_USE_STALL_EN defined: the hazard logic above is active.
- Undefined: hazard is tied to 0 and ex_is_load_i is ignored. Load-use scheduling is then the compiler's responsibility, and slot-0 data is forwarded unconditionally.

## Test plan

- Reset with rst=0 mid-stream → all outputs 0 and out_valid=0 within the same cycle. The first accepted instruction appears one cycle after acceptance.
- ADDI x5,x1,-1 (0xFFF08293) with x1=10 from the regfile → imm_o=0xFFFF_FFFF_FFFF_FFFF, rs1_data_o=10, rd=5, wreg=1.
- ADD x3,x1,x2 with slot 0 and slot 2 both writing x1 (0xAA and 0xBB) → rs1_data_o=0xAA. With rs1=x0 and a slot writing x0 → 0.
- LD x7 in EX (ex_is_load_i=1, rd0=7), then ADD x8,x7,x7 → in_ready=0 for one cycle and a bubble is emitted. The next cycle, with slot 1 supplying 0x1234, the instruction is accepted with rs1=rs2=0x1234. With the macro undefined, there is no stall.
- out_ready=0 for 3 cycles while valid → outputs held, in_ready=0, and no instruction is lost or duplicated.
- BEQ with offset -4 → imm_o=0xFFFF_FFFF_FFFF_FFFC and wreg=0. flush_i in the same cycle → out_valid=0 the next cycle.
